// File: rtl/aes_key_sched_seq_if.sv
// ---------------------------------------------------------------------------
// aes_key_sched_seq_if
//
// Purpose: bundles the control, key-load and round-key read signals of the
// sequential AES key-schedule engine into one interface.
//
// Signals:
//   start      : single-cycle request to expand `key` under `Algorithm`
//   key        : 256-bit cipher key, MSB-aligned
//   Algorithm  : 00 = AES-128, 01 = AES-256, 10 = AES-192, 11 = illegal
//   busy       : expansion in progress
//   ready      : a complete schedule is held for the latched algorithm
//   nr         : round count Nr of the latched algorithm
//   cfg_err    : one-cycle pulse when a start is rejected
//   rd_en      : round-key read request
//   rd_idx     : requested round index
//   rd_inv     : 1 = reverse order (round = Nr - rd_idx)
//   rd_key     : registered round key, word w[4r] in [127:96]
//   rd_valid   : rd_key is valid this cycle
//   rd_err     : requested index was out of range
//
// Modports: master drives requests (key loader / round datapath),
//           slave is the key-schedule engine.
// ---------------------------------------------------------------------------
interface aes_key_sched_seq_if;
  logic         start;
  logic [255:0] key;
  logic [1:0]   Algorithm;
  logic         busy;
  logic         ready;
  logic [3:0]   nr;
  logic         cfg_err;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic         rd_inv;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_err;

  modport master (
    output start, key, Algorithm, rd_en, rd_idx, rd_inv,
    input  busy, ready, nr, cfg_err, rd_key, rd_valid, rd_err
  );

  modport slave (
    input  start, key, Algorithm, rd_en, rd_idx, rd_inv,
    output busy, ready, nr, cfg_err, rd_key, rd_valid, rd_err
  );
endinterface

// File: rtl/aes_key_sched_seq.sv
// ---------------------------------------------------------------------------
// aes_key_sched_seq
//
// Purpose: sequential AES key-schedule engine for AES-128/192/256. After a
// start it loads the Nk key words in one cycle, then generates one expanded
// 32-bit word per clock into an internal word store. Once complete, any
// round key can be read by index in forward or reverse order with a
// one-cycle registered read latency.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : aes_key_sched_seq_if.slave (start/key/Algorithm, status outputs,
//         rd_en/rd_idx/rd_inv read request, rd_key/rd_valid/rd_err result)
//
// Parameters:
//   MAX_WORDS : depth of the word store, must be >= 60
//
// Configuration macro:
//   AES_KEY_INV_MIXCOL_EN : when defined, reverse-order reads of rounds
//   1..Nr-1 return InvMixColumns of the round key (equivalent inverse
//   cipher); rounds 0 and Nr stay raw. Undefined: all reads are raw.
// ---------------------------------------------------------------------------
module aes_key_sched_seq #(
  parameter int MAX_WORDS = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_sched_seq_if.slave   bus
);

  localparam int IW = $clog2(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GEN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // GF(2^8) helpers and the S-box (inverse in GF(2^8) followed by the affine
  // transform), so no lookup table is needed.
  // -------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

`ifdef AES_KEY_INV_MIXCOL_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t         state_q,    state_d;
  logic [255:0]   key_q,      key_d;
  logic [3:0]     nk_q,       nk_d;
  logic [3:0]     nr_q,       nr_d;
  logic [31:0]    hist_q [8];
  logic [31:0]    hist_d [8];
  logic [IW-1:0]  i_q,        i_d;
  logic [IW-1:0]  last_q,     last_d;
  logic [2:0]     mod_q,      mod_d;
  logic [7:0]     rcon_q,     rcon_d;
  logic           busy_q,     busy_d;
  logic           ready_q,    ready_d;
  logic           cfg_err_q,  cfg_err_d;
  logic [127:0]   rd_key_q,   rd_key_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_err_q,   rd_err_d;

  logic [31:0]    store_q [MAX_WORDS];

  // -------------------------------------------------------------------------
  // Word generator. hist_q[0] is w[i-1] and hist_q[Nk-1] is w[i-Nk], so the
  // store is never read during expansion. The four S-box lanes are shared
  // between the RotWord+rcon step and the AES-256 mid-key SubWord step.
  // -------------------------------------------------------------------------
  logic [31:0] prev_w;
  logic [31:0] far_w;
  logic [3:0]  nk_m1;
  logic        do_rot;
  logic        do_sub;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic [31:0] temp_w;
  logic [31:0] new_w;

  always_comb begin
    nk_m1    = nk_q - 4'd1;
    prev_w   = hist_q[0];
    far_w    = hist_q[nk_m1[2:0]];
    do_rot   = (mod_q == 3'd0);
    do_sub   = (nk_q == 4'd8) && (mod_q == 3'd4);
    sbox_in  = do_rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sbox_out = {sbox(sbox_in[31:24]), sbox(sbox_in[23:16]),
                sbox(sbox_in[15:8]),  sbox(sbox_in[7:0])};
    if (do_rot)
      temp_w = sbox_out ^ {rcon_q, 24'h000000};
    else if (do_sub)
      temp_w = sbox_out;
    else
      temp_w = prev_w;
    new_w = far_w ^ temp_w;
  end

  // -------------------------------------------------------------------------
  // Read path. An out-of-range index is clamped to round 0 for addressing
  // only; its result is forced to zero with rd_err set.
  // -------------------------------------------------------------------------
  logic           rd_oor;
  logic [3:0]     rd_round;
  logic [IW-1:0]  rd_base;
  logic [127:0]   rd_word;

  always_comb begin
    rd_oor   = (bus.rd_idx > nr_q);
    rd_round = 4'd0;
    if (!rd_oor)
      rd_round = bus.rd_inv ? (nr_q - bus.rd_idx) : bus.rd_idx;
    rd_base  = IW'({rd_round, 2'b00});
    rd_word  = {store_q[rd_base],           store_q[rd_base + IW'(1)],
                store_q[rd_base + IW'(2)],  store_q[rd_base + IW'(3)]};
`ifdef AES_KEY_INV_MIXCOL_EN
    // Equivalent inverse cipher wants InvMixColumns on the middle rounds.
    if (bus.rd_inv && (bus.rd_idx != 4'd0) && (bus.rd_idx != nr_q))
      rd_word = {inv_mix_col(rd_word[127:96]), inv_mix_col(rd_word[95:64]),
                 inv_mix_col(rd_word[63:32]),  inv_mix_col(rd_word[31:0])};
`endif
  end

  // -------------------------------------------------------------------------
  // Next-state logic for the FSM, expansion counters and read outputs.
  // Starts are only considered in IDLE/DONE; a busy engine ignores them.
  // -------------------------------------------------------------------------
  logic idle_like;
  logic [5:0] last_word;

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    hist_d     = hist_q;
    i_d        = i_q;
    last_d     = last_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    cfg_err_d  = 1'b0;
    rd_key_d   = rd_key_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    idle_like  = (state_q == IDLE) || (state_q == DONE);
    last_word  = {nr_q, 2'b00} + 6'd3;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.Algorithm == 2'b11) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = LOAD;
            key_d   = bus.key;
            busy_d  = 1'b1;
            ready_d = 1'b0;
            case (bus.Algorithm)
              2'b00:   begin nk_d = 4'd4; nr_d = 4'd10; end
              2'b01:   begin nk_d = 4'd8; nr_d = 4'd14; end
              default: begin nk_d = 4'd6; nr_d = 4'd12; end
            endcase
          end
        end
      end

      LOAD: begin
        // Seed history newest-first: hist[0] = w[Nk-1], hist[Nk-1] = w[0].
        for (int k = 0; k < 8; k++) begin
          hist_d[k] = 32'h0;
          if (4'(k) < nk_q)
            hist_d[k] = key_q[(7 - (int'(nk_q) - 1 - k)) * 32 +: 32];
        end
        i_d     = IW'(nk_q);
        mod_d   = 3'd0;
        rcon_d  = 8'h01;
        last_d  = IW'(last_word);
        state_d = GEN;
      end

      GEN: begin
        hist_d[0] = new_w;
        for (int k = 1; k < 8; k++)
          hist_d[k] = hist_q[k - 1];
        i_d   = i_q + IW'(1);
        mod_d = ({1'b0, mod_q} == nk_m1) ? 3'd0 : mod_q + 3'd1;
        if (do_rot)
          rcon_d = xtime(rcon_q);
        if (i_q == last_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (!idle_like)
      cfg_err_d = 1'b0;

    // ready_q is still the old value on the edge a start is accepted, so a
    // coincident read is served from the old schedule.
    if (bus.rd_en && ready_q) begin
      rd_valid_d = 1'b1;
      if (rd_oor) begin
        rd_err_d = 1'b1;
        rd_key_d = 128'h0;
      end else begin
        rd_key_d = rd_word;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control and output registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      key_q      <= '0;
      nk_q       <= 4'd0;
      nr_q       <= 4'd0;
      for (int k = 0; k < 8; k++)
        hist_q[k] <= 32'h0;
      i_q        <= '0;
      last_q     <= '0;
      mod_q      <= 3'd0;
      rcon_q     <= 8'h01;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
      rd_key_q   <= 128'h0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      hist_q     <= hist_d;
      i_q        <= i_d;
      last_q     <= last_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      cfg_err_q  <= cfg_err_d;
      rd_key_q   <= rd_key_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Word store. Contents are don't-care after reset (ready gates all reads),
  // so it carries no reset and maps onto plain storage.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      for (int k = 0; k < 8; k++)
        if (4'(k) < nk_q)
          store_q[IW'(k)] <= key_q[(7 - k) * 32 +: 32];
    end else if (state_q == GEN) begin
      store_q[i_q] <= new_w;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.nr       = nr_q;
  assign bus.cfg_err  = cfg_err_q;
  assign bus.rd_key   = rd_key_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;

endmodule

// File: doc/aes_key_sched_seq.md
# aes_key_sched_seq

Sequential AES key-schedule engine covering AES-128, AES-192 and AES-256 from one 256-bit key input. It expands the cipher key one 32-bit word per clock into an internal round-key store. Afterwards it serves any round key by index, in forward (encryption) or reverse (decryption) order. It sits between key loading and the round datapath of both the encrypt and decrypt cores, replacing per-round combinational expansion.

## Interface
- `MAX_WORDS`, default 60: depth of the word store (4·(Nr+1) for AES-256); must be ≥60.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle pulse; begin expansion of `key` under `Algorithm`.
- `key`  in  256: cipher key, MSB-aligned. AES-128 uses [255:128], AES-192 uses [255:64], AES-256 uses all bits.
- `Algorithm`  in  2: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-256 (Nk=8, Nr=14), 10 = AES-192 (Nk=6, Nr=12), 11 = illegal.
- `busy`  out  1: expansion in progress.
- `ready`  out  1: store holds a complete schedule for the latched algorithm.
- `nr`  out  4: Nr of the latched algorithm (0 until the first accepted start).
- `cfg_err`  out  1: one-cycle pulse when a start is rejected.
- `rd_en`  in  1: read request.
- `rd_idx`  in  4: round index requested.
- `rd_inv`  in  1: 1 = reverse order (round = Nr − rd_idx).
- `rd_key`  out  128: round key; word w[4r] in [127:96].
- `rd_valid`  out  1: `rd_key` is valid this cycle.
- `rd_err`  out  1: out-of-range index flagged with `rd_valid`.

## Operation
- FSM states: IDLE, LOAD, GEN, DONE.
- IDLE/DONE + `start` with legal `Algorithm`:
  - latch key and algorithm; go to LOAD.
  - `busy` = 1, `ready` = 0 from the next edge.
- `start` with `Algorithm` = 11: no state change, `ready` unchanged, `cfg_err` pulses for 1 cycle.
- `start` while busy (LOAD/GEN): ignored, no error.
- LOAD (1 cycle): write w[0..Nk−1] from the key; seed the 8-word history register; rcon = 0x01.
- GEN (1 word/cycle, i = Nk … 4(Nr+1)−1):
  - temp = w[i−1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon).
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i−Nk] ^ temp.
  - w[i−1] and w[i−Nk] come from the history shift register, not the store.
  - Four S-box instances are used, shared by both SubWord cases.
- After the last word: go to DONE; `busy` = 0, `ready` = 1.
- Word counts generated: 40 / 46 / 52 for AES-128 / 192 / 256.
- Reads:
  - Read-only while `ready`.
  - `rd_en` while not ready: `rd_valid` = 0, `rd_key` holds.
  - A read on the same edge as an accepted `start` uses the old schedule.
- Out of range (`rd_idx` > Nr): `rd_valid` = 1, `rd_err` = 1, `rd_key` = 0.

## Timing
- Reset values: state IDLE; `busy`, `ready`, `cfg_err`, `rd_valid`, `rd_err` = 0; `nr` = 0; `rd_key` = 0.
- Reset mid-expansion aborts immediately; the store contents are don't-care, `ready` = 0.
- With `start` sampled at edge E0:
  - LOAD writes at E1.
  - GEN words are written at E2 … E(1+G), where G is the word count above.
  - `ready` rises at E(1+G): 41 / 47 / 53 cycles after E0.
- Read latency is 1 cycle: `rd_en` sampled at edge E gives registered `rd_key`/`rd_valid`/`rd_err` valid after E. Back-to-back reads give one result per cycle.
- `cfg_err`, `rd_valid` and `rd_err` are single-cycle unless re-requested.

## Configuration
- `AES_KEY_INV_MIXCOL_EN` defined:
  - Reverse-order reads of rounds 1…Nr−1 return InvMixColumns applied to each column of the round key (equivalent inverse cipher).
  - Rounds 0 and Nr are returned raw.
  - This logic sits in the read path; read latency stays 1 cycle.
- `AES_KEY_INV_MIXCOL_EN` undefined: all reads return raw round keys; no InvMixColumns logic is present.

## Test plan
- AES-128, key[255:128] = 000102030405060708090a0b0c0d0e0f:
  - `ready` exactly 41 cycles after start.
  - rd_idx = 10, rd_inv = 0 → 13111d7fe3944a17f307a78b4d2b30c5.
  - rd_idx = 0, rd_inv = 1 → the same value.
- AES-192, key[255:64] = 000102…1617: `ready` after 47 cycles; round 12 → a4970a331a78dc09c418c271e3a41d5d.
- AES-256, key = 000102…1e1f, `Algorithm` = 01:
  - round 13 → 4e5a6699a9f24fe07e572baacdf8cdea.
  - round 14 → 24fc79ccbf0979e9371ac23c6d68de36.
  - rd_inv = 1 sweep over rd_idx 0…14 returns rounds 14…0.
- Error handling:
  - `Algorithm` = 11 + start → `cfg_err` pulse, `busy` stays 0.
  - AES-128 schedule ready, rd_idx = 12 → `rd_err` = 1, `rd_key` = 0.
  - `rd_en` before `ready` → `rd_valid` = 0.
- Assert `rst` at cycle 20 of an AES-256 expansion → all outputs return to reset values. A fresh start then completes correctly in 53 cycles. A start issued mid-GEN is ignored.
- With `AES_KEY_INV_MIXCOL_EN` defined, AES-128 2b7e151628aed2a6abf7158809cf4f3c, rd_inv = 1:
  - rd_idx = 0 → d014f9a8c9ee2589e13f0cc8b6630ca6 (raw).
  - rd_idx = 1…9 → InvMixColumns of the reference-model round keys.
